// File: rtl/qspi_boot_ctrl.sv
// qspi_boot_ctrl: copies a boot image out of SPI flash (READ 0x03, mode 0)
// into instruction RAM one 32-bit word at a time, then raises fetch_enable.
module qspi_boot_ctrl #(
    parameter int unsigned CLK_DIV         = 2,
    parameter logic [23:0] FLASH_BASE_ADDR = 24'h000000,
    parameter int unsigned BOOT_WORDS      = 1024,
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        qspi_clk_o,
    output logic        qspi_csn_o,
    output logic        qspi_sdo_o,
    input  logic        qspi_sdi_i,
    output logic        qspi_wpn_o,
    output logic        qspi_holdn_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fetch_enable_o
);

    typedef enum logic [2:0] {
        IDLE, CS_SETUP, CMD, ADDR, DATA, WRITE, CS_HOLD, DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [16:0] LAST_WORD = 17'(BOOT_WORDS - 1);
    localparam logic [31:0] READ_HDR  = {8'h03, FLASH_BASE_ADDR};

    state_t      state, state_next;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [16:0] word_cnt;
    logic [31:0] tx_sr, rx_sr;
    logic        shifting, timed, div_end, sck_rise, sck_fall, seg_end, last_word;

    assign qspi_wpn_o     = 1'b1;
    assign qspi_holdn_o   = 1'b1;
    assign mem_we_o       = mem_req_o;
    assign mem_be_o       = 4'hF;
    assign fetch_enable_o = done_o;

    always_comb begin
        shifting   = (state == CMD) || (state == ADDR) || (state == DATA);
        timed      = shifting || (state == CS_SETUP) || (state == CS_HOLD);
        div_end    = (div_cnt == DIV_LAST);
        sck_rise   = shifting && div_end && !qspi_clk_o;
        sck_fall   = shifting && div_end && qspi_clk_o;
        seg_end    = ((state == CMD)  && (bit_cnt == 5'd7))  ||
                     ((state == ADDR) && (bit_cnt == 5'd23)) ||
                     ((state == DATA) && (bit_cnt == 5'd31));
        last_word  = (word_cnt == LAST_WORD);
        state_next = state;
        case (state)
            IDLE:     if (start_i) state_next = (BOOT_WORDS == 0) ? DONE : CS_SETUP;
            CS_SETUP: if (div_end) state_next = CMD;
            CMD:      if (sck_fall && seg_end) state_next = ADDR;
            ADDR:     if (sck_fall && seg_end) state_next = DATA;
            DATA:     if (sck_fall && seg_end) state_next = WRITE;
            WRITE:    if (mem_gnt_i) state_next = last_word ? CS_HOLD : DATA;
            CS_HOLD:  if (div_end) state_next = DONE;
            default:  state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qspi_csn_o  <= 1'b1;
            qspi_clk_o  <= 1'b0;
            qspi_sdo_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
        end else begin
            div_cnt <= (timed && !div_end) ? div_cnt + 8'd1 : '0;
            case (state)
                IDLE: if (start_i) begin
                    busy_o     <= (BOOT_WORDS != 0);
                    qspi_csn_o <= (BOOT_WORDS == 0);
                    mem_addr_o <= MEM_BASE;
                    tx_sr      <= READ_HDR;
                    word_cnt   <= '0;
                end
                CS_SETUP: if (div_end) begin
                    qspi_sdo_o <= tx_sr[31];
                    tx_sr      <= {tx_sr[30:0], 1'b0};
                    bit_cnt    <= '0;
                end
                CMD, ADDR, DATA: begin
                    // rx_sr also fills during CMD/ADDR; DATA overwrites all 32 bits.
                    if (sck_rise) begin
                        qspi_clk_o <= 1'b1;
                        rx_sr      <= {rx_sr[30:0], qspi_sdi_i};
                    end
                    if (sck_fall) begin
                        qspi_clk_o <= 1'b0;
                        bit_cnt    <= seg_end ? '0 : bit_cnt + 5'd1;
                        if ((state == DATA) || ((state == ADDR) && seg_end)) begin
                            qspi_sdo_o <= 1'b0;
                        end else begin
                            qspi_sdo_o <= tx_sr[31];
                            tx_sr      <= {tx_sr[30:0], 1'b0};
                        end
                        if ((state == DATA) && seg_end) begin
                            mem_req_o   <= 1'b1;
                            mem_wdata_o <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
                        end
                    end
                end
                WRITE: if (mem_gnt_i) begin
                    mem_req_o  <= 1'b0;
                    mem_addr_o <= mem_addr_o + 32'd4;
                    word_cnt   <= word_cnt + 17'd1;
                    if (last_word) qspi_csn_o <= 1'b1;
                end
                DONE: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
